array_21_port_ctrl: RTL



---
 rtl/array_21_port_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/array_21_port_ctrl.sv
// Arbitrates ready/valid write and read requests onto the RW0 port of a single-port data array.
// Read data is returned in request order through a small response FIFO. ARRAY_21_PORT_CTRL_STATS_EN adds counters.
module array_21_port_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 256,
  parameter int MASK_W     = 16,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_wreq_valid,
  output logic              io_wreq_ready,
  input  logic [ADDR_W-1:0] io_wreq_addr,
  input  logic [MASK_W-1:0] io_wreq_mask,
  input  logic [DATA_W-1:0] io_wreq_data,
  input  logic              io_rreq_valid,
  output logic              io_rreq_ready,
  input  logic [ADDR_W-1:0] io_rreq_addr,
  output logic              io_rresp_valid,
  input  logic              io_rresp_ready,
  output logic [DATA_W-1:0] io_rresp_data,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
`ifdef ARRAY_21_PORT_CTRL_STATS_EN
  ,
  output logic [31:0]       io_stat_wr_cnt,
  output logic [31:0]       io_stat_rd_cnt,
  output logic [31:0]       io_stat_conflict_cnt
`endif
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  typedef enum logic {
    PRIO_WRITE = 1'b0,
    PRIO_READ  = 1'b1
  } prio_e;

  prio_e             prio_q, prio_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [RESP_DEPTH];
  logic [DATA_W-1:0] mem_d [RESP_DEPTH];

  logic [CNT_W:0]    occ_s;
  logic              credit_s;
  logic              rd_elig_s;
  logic              both_req_s;
  logic              wfire_s;
  logic              rfire_s;
  logic              enq_s;
  logic              deq_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1'b1);
  endfunction

  // Handshake, arbitration and array port drive
  always_comb begin
    // The read in flight already owns a FIFO slot, so it counts against credit.
    occ_s          = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    credit_s       = occ_s < (CNT_W + 1)'(RESP_DEPTH);
    rd_elig_s      = io_rreq_valid && credit_s;
    both_req_s     = io_wreq_valid && io_rreq_valid;
    io_wreq_ready  = !reset && (!rd_elig_s || (prio_q == PRIO_WRITE));
    io_rreq_ready  = !reset && credit_s && (!io_wreq_valid || (prio_q == PRIO_READ));
    wfire_s        = io_wreq_valid && io_wreq_ready;
    rfire_s        = io_rreq_valid && io_rreq_ready;
    RW0_en         = wfire_s || rfire_s;
    RW0_wmode      = wfire_s;
    RW0_addr       = wfire_s ? io_wreq_addr : io_rreq_addr;
    RW0_wmask      = wfire_s ? io_wreq_mask : {MASK_W{1'b0}};
    RW0_wdata      = io_wreq_data;
    io_rresp_valid = !reset && (count_q != {CNT_W{1'b0}});
    io_rresp_data  = mem_q[head_q];
    enq_s          = inflight_q;
    deq_s          = io_rresp_valid && io_rresp_ready;
  end

  // Next-state for priority, read pipeline and FIFO bookkeeping
  always_comb begin
    prio_d     = prio_q;
    inflight_d = rfire_s;
    head_d     = deq_s ? ptr_inc(head_q) : head_q;
    tail_d     = enq_s ? ptr_inc(tail_q) : tail_q;
    count_d    = count_q;
    if (both_req_s && wfire_s) begin
      prio_d = PRIO_READ;
    end else if (both_req_s && rfire_s) begin
      prio_d = PRIO_WRITE;
    end else begin
      prio_d = prio_q;
    end
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
    for (int i = 0; i < RESP_DEPTH; i++) begin
      mem_d[i] = (enq_s && (tail_q == PTR_W'(i))) ? RW0_rdata : mem_q[i];
    end
  end

  // Control state, cleared by reset (discarding any in-flight read)
  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q     <= PRIO_WRITE;
      inflight_q <= 1'b0;
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
    end else begin
      prio_q     <= prio_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Response FIFO storage; contents are qualified by count so need no reset
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef ARRAY_21_PORT_CTRL_STATS_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic        conflict_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // Saturating event counters; a read held back only by credit is not a conflict
  always_comb begin
    conflict_s     = both_req_s && credit_s && (wfire_s || rfire_s);
    wr_cnt_d       = sat_inc(wr_cnt_q, wfire_s);
    rd_cnt_d       = sat_inc(rd_cnt_q, rfire_s);
    conflict_cnt_d = sat_inc(conflict_cnt_q, conflict_s);
  end

  // Counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt_q       <= 32'd0;
      rd_cnt_q       <= 32'd0;
      conflict_cnt_q <= 32'd0;
    end else begin
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign io_stat_wr_cnt       = wr_cnt_q;
  assign io_stat_rd_cnt       = rd_cnt_q;
  assign io_stat_conflict_cnt = conflict_cnt_q;
`endif

endmodule
